// File: rtl/laser_cover_search.sv
// Two-circle cover search: loads NPTS grid points, then alternately optimises
// circle centre C1 (with C2 held) and C2 (with C1 held) over the whole G x G
// grid, ITER times, and reports both centres and the covered-point count.
module laser_cover_search #(
    parameter int NPTS   = 40,
    parameter int W      = 4,
    parameter int RADIUS = 4,
    parameter int ITER   = 2,
    parameter int CW     = $clog2(NPTS + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [W-1:0]  X,
    input  logic [W-1:0]  Y,
    output logic [W-1:0]  C1X,
    output logic [W-1:0]  C1Y,
    output logic [W-1:0]  C2X,
    output logic [W-1:0]  C2Y,
    output logic [CW-1:0] COUNT,
    output logic          DONE
);

    localparam int          KW     = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int          PW     = $clog2(2 * ITER + 1);
    localparam int          SW     = 2 * W + 1;
    localparam int unsigned R2     = RADIUS * RADIUS;
    localparam logic [KW-1:0] K_LAST = KW'(NPTS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(2 * ITER - 1);
    localparam logic [W-1:0]  G_MAX  = {W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SEARCH,
        ST_REPORT
    } state_t;

    // Point covered iff squared distance (2W+1 bits, no overflow) <= RADIUS^2.
    function automatic logic in_circle(input logic [W-1:0] cx, input logic [W-1:0] cy,
                                       input logic [W-1:0] px, input logic [W-1:0] py);
        logic [W-1:0]  dx;
        logic [W-1:0]  dy;
        logic [SW-1:0] d2;
        dx = (cx > px) ? (cx - px) : (px - cx);
        dy = (cy > py) ? (cy - py) : (py - cy);
        d2 = SW'(dx) * SW'(dx) + SW'(dy) * SW'(dy);
        return (32'(d2) <= R2);
    endfunction

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] best_q, best_d;
    logic [W-1:0]  candx_q, candx_d, candy_q, candy_d;
    logic [W-1:0]  c1x_q, c1x_d, c1y_q, c1y_d;
    logic [W-1:0]  c2x_q, c2x_d, c2y_q, c2y_d;
    logic [W-1:0]  res_c1x_q, res_c1x_d, res_c1y_q, res_c1y_d;
    logic [W-1:0]  res_c2x_q, res_c2x_d, res_c2y_q, res_c2y_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;
    logic          done_q, done_d;

    logic [W-1:0]  pts_x_q [NPTS];
    logic [W-1:0]  pts_y_q [NPTS];

    logic [W-1:0]  pt_x, pt_y, held_x, held_y;
    logic          cov;
    logic [CW-1:0] total;
    logic [CW-1:0] best_new;
    logic          cand_last;

    // Point store: written only while loading, one point per edge at index k.
    always_ff @(posedge CLK) begin
        if (state_q == ST_LOAD) begin
            pts_x_q[k_q] <= X;
            pts_y_q[k_q] <= Y;
        end
    end

    // Next-state, search datapath and result capture.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        best_d    = best_q;
        candx_d   = candx_q;
        candy_d   = candy_q;
        c1x_d     = c1x_q;
        c1y_d     = c1y_q;
        c2x_d     = c2x_q;
        c2y_d     = c2y_q;
        res_c1x_d = res_c1x_q;
        res_c1y_d = res_c1y_q;
        res_c2x_d = res_c2x_q;
        res_c2y_d = res_c2y_q;
        res_cnt_d = res_cnt_q;
        done_d    = 1'b0;

        // Even passes move C1 against a fixed C2; odd passes the reverse.
        pt_x      = pts_x_q[k_q];
        pt_y      = pts_y_q[k_q];
        held_x    = pass_q[0] ? c1x_q : c2x_q;
        held_y    = pass_q[0] ? c1y_q : c2y_q;
        cov       = in_circle(candx_q, candy_q, pt_x, pt_y) |
                    in_circle(held_x, held_y, pt_x, pt_y);
        total     = cnt_q + CW'(cov);
        best_new  = best_q;
        cand_last = (candx_q == G_MAX) && (candy_q == G_MAX);

        case (state_q)
            ST_LOAD: begin
                if (k_q == K_LAST) begin
                    state_d = ST_SEARCH;
                    k_d     = '0;
                    pass_d  = '0;
                    cnt_d   = '0;
                    best_d  = '0;
                    candx_d = '0;
                    candy_d = '0;
                    c1x_d   = '0;
                    c1y_d   = '0;
                    c2x_d   = G_MAX;
                    c2y_d   = G_MAX;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_SEARCH: begin
                if (k_q != K_LAST) begin
                    k_d   = k_q + KW'(1);
                    cnt_d = total;
                end else begin
                    k_d   = '0;
                    cnt_d = '0;
                    // Strictly greater: ties keep the earlier candidate, and a
                    // pass that never covers anything leaves the centre alone.
                    if (total > best_q) begin
                        best_new = total;
                        if (pass_q[0]) begin
                            c2x_d = candx_q;
                            c2y_d = candy_q;
                        end else begin
                            c1x_d = candx_q;
                            c1y_d = candy_q;
                        end
                    end
                    best_d = best_new;
                    if (cand_last) begin
                        candx_d = '0;
                        candy_d = '0;
                        if (pass_q == P_LAST) begin
                            state_d   = ST_REPORT;
                            done_d    = 1'b1;
                            res_c1x_d = c1x_d;
                            res_c1y_d = c1y_d;
                            res_c2x_d = c2x_d;
                            res_c2y_d = c2y_d;
                            res_cnt_d = best_new;
                        end else begin
                            pass_d = pass_q + PW'(1);
                            best_d = '0;
                        end
                    end else if (candx_q == G_MAX) begin
                        candx_d = '0;
                        candy_d = candy_q + W'(1);
                    end else begin
                        candx_d = candx_q + W'(1);
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_LOAD;
                k_d     = '0;
            end
            default: begin
                state_d = ST_LOAD;
                k_d     = '0;
            end
        endcase
    end

    // Control, work and result registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_LOAD;
            k_q       <= '0;
            pass_q    <= '0;
            cnt_q     <= '0;
            best_q    <= '0;
            candx_q   <= '0;
            candy_q   <= '0;
            c1x_q     <= '0;
            c1y_q     <= '0;
            c2x_q     <= '0;
            c2y_q     <= '0;
            res_c1x_q <= '0;
            res_c1y_q <= '0;
            res_c2x_q <= '0;
            res_c2y_q <= '0;
            res_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
            best_q    <= best_d;
            candx_q   <= candx_d;
            candy_q   <= candy_d;
            c1x_q     <= c1x_d;
            c1y_q     <= c1y_d;
            c2x_q     <= c2x_d;
            c2y_q     <= c2y_d;
            res_c1x_q <= res_c1x_d;
            res_c1y_q <= res_c1y_d;
            res_c2x_q <= res_c2x_d;
            res_c2y_q <= res_c2y_d;
            res_cnt_q <= res_cnt_d;
            done_q    <= done_d;
        end
    end

    assign C1X   = res_c1x_q;
    assign C1Y   = res_c1y_q;
    assign C2X   = res_c2x_q;
    assign C2Y   = res_c2y_q;
    assign COUNT = res_cnt_q;
    assign DONE  = done_q;

endmodule
